// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: sequencer states,
// mode-byte field positions and baud divisors used by the serializer.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    WAIT_MEM = 3'd2,
    WAIT_CTS = 3'd3,
    SEND     = 3'd4,
    WAIT_TX  = 3'd5,
    FINISH   = 3'd6
  } seq_state_t;

  localparam int MODE_BAUD_HI   = 7;
  localparam int MODE_BAUD_LO   = 6;
  localparam int MODE_STOP_ONE  = 5;
  localparam int MODE_PAR_SENSE = 1;
  localparam int MODE_PAR_EN    = 0;

  // Divisors for a 100 MHz bit clock: 9600, 19200, 38400, 115200 baud.
  localparam logic [13:0] BAUD_DIV_9600   = 14'd10416;
  localparam logic [13:0] BAUD_DIV_19200  = 14'd5208;
  localparam logic [13:0] BAUD_DIV_38400  = 14'd2604;
  localparam logic [13:0] BAUD_DIV_115200 = 14'd868;

  function automatic logic [13:0] baud_divisor(input logic [1:0] sel);
    case (sel)
      2'd0:    return BAUD_DIV_9600;
      2'd1:    return BAUD_DIV_19200;
      2'd2:    return BAUD_DIV_38400;
      default: return BAUD_DIV_115200;
    endcase
  endfunction

endpackage

// File: rtl/cts_timeout_counter.sv
// Loadable down-counter bounding the time spent waiting for CTS;
// expired is high while the count sits at zero.
module cts_timeout_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && !expired) begin
      count <= count - ONE;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/uart_tx_sequencer.sv
// Walks the Tx serializer through a burst of bytes from memory, running the
// RTS/CTS handshake and holding the operating mode fixed for the burst.
//
// state    | meaning
// IDLE     | waiting for GO
// FETCH    | read strobe for the current byte
// WAIT_MEM | memory data arrives, captured into TX_DATA
// WAIT_CTS | waiting for the receiver, bounded by CTS_TIMEOUT
// SEND     | one-cycle start pulse to the serializer
// WAIT_TX  | byte in flight until TX_DONE
// FINISH   | end-of-burst pulse, RTS released
module uart_tx_sequencer
  import uart_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int CNT_W       = 16,
  parameter int CTS_TIMEOUT = 50000
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              GO,
  input  logic              ABORT,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic [CNT_W-1:0]  PKT_COUNT,
  input  logic [7:0]        MODE_IN,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_RD,
  input  logic [7:0]        MEM_DATA,
  output logic              TX_START,
  output logic [7:0]        TX_DATA,
  output logic [7:0]        TX_MODE,
  input  logic              TX_DONE,
  input  logic              CTS,
  output logic              RTS,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR_TIMEOUT,
  output logic [CNT_W-1:0]  SENT_COUNT
);

  localparam int                 TO_W     = $clog2(CTS_TIMEOUT + 1);
  localparam logic [TO_W-1:0]    TO_LOAD  = TO_W'(CTS_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0]  ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  seq_state_t       state, state_nx;
  logic [CNT_W-1:0] remaining;
  logic             cts_expired;
  logic             last_byte;

  assign last_byte = (remaining == CNT_ONE);

  // The counter is armed while the byte is being read, so it is full on entry to WAIT_CTS.
  cts_timeout_counter #(.W(TO_W)) u_cts_timeout (
    .clk      (Clock),
    .rst      (Reset),
    .load     (state == WAIT_MEM),
    .load_val (TO_LOAD),
    .en       (state == WAIT_CTS),
    .expired  (cts_expired)
  );

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (GO) state_nx = (PKT_COUNT == '0) ? FINISH : FETCH;
      FETCH:    state_nx = ABORT ? FINISH : WAIT_MEM;
      WAIT_MEM: state_nx = ABORT ? FINISH : WAIT_CTS;
      WAIT_CTS: begin
        if (ABORT)            state_nx = FINISH;
        else if (CTS)         state_nx = SEND;
        else if (cts_expired) state_nx = FINISH;
      end
      SEND:     state_nx = WAIT_TX;
      WAIT_TX:  if (TX_DONE) state_nx = (last_byte || ABORT) ? FINISH : FETCH;
      FINISH:   state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    MEM_RD   = 1'b0;
    TX_START = 1'b0;
    RTS      = 1'b0;
    BUSY     = 1'b1;
    DONE     = 1'b0;
    case (state)
      IDLE:  BUSY = 1'b0;
      FETCH: begin
        MEM_RD = 1'b1;
        RTS    = 1'b1;
      end
      WAIT_MEM, WAIT_CTS, WAIT_TX: RTS = 1'b1;
      SEND: begin
        TX_START = !Reset;
        RTS      = 1'b1;
      end
      FINISH:  DONE = 1'b1;
      default: BUSY = 1'b0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      MEM_ADDR    <= '0;
      TX_DATA     <= '0;
      TX_MODE     <= '0;
      ERR_TIMEOUT <= 1'b0;
      SENT_COUNT  <= '0;
      remaining   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (GO) begin
            ERR_TIMEOUT <= 1'b0;
            SENT_COUNT  <= '0;
            if (PKT_COUNT != '0) begin
              MEM_ADDR  <= BASE_ADDR;
              remaining <= PKT_COUNT;
              TX_MODE   <= MODE_IN;
            end
          end
        end
        WAIT_MEM: TX_DATA <= MEM_DATA;
        WAIT_CTS: begin
          if (!ABORT && !CTS && cts_expired) ERR_TIMEOUT <= 1'b1;
        end
        WAIT_TX: begin
          if (TX_DONE) begin
            SENT_COUNT <= SENT_COUNT + CNT_ONE;
            remaining  <= remaining - CNT_ONE;
            MEM_ADDR   <= MEM_ADDR + ADDR_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for uart_tx_sequencer: a burst-level reference model checked every
// cycle, plus literal expectations for each directed scenario.
module tb_uart_tx_sequencer;

  localparam int TO_MAIN = 1000;
  localparam int TO_SHORT = 16;
  localparam int SER_DLY = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0, go_t = 1'b0, abort = 1'b0, cts = 1'b1;
  logic        tx_done = 1'b0, t_tx_done = 1'b0;
  logic [7:0]  base = '0, mode_in = '0, mem_data = '0, t_mem_data = '0;
  logic [15:0] pkt = '0;

  logic [7:0]  mem_addr, tx_data, tx_mode;
  logic        mem_rd, tx_start, rts, busy, done, err;
  logic [15:0] sent;
  logic [7:0]  t_mem_addr, t_tx_data, t_tx_mode;
  logic        t_mem_rd, t_tx_start, t_rts, t_busy, t_done, t_err;
  logic [15:0] t_sent;

  logic [7:0]  mem [256];

  always #5 clk = ~clk;

  uart_tx_sequencer #(.ADDR_W(8), .CNT_W(16), .CTS_TIMEOUT(TO_MAIN)) dut (
    .Clock(clk), .Reset(rst), .GO(go), .ABORT(abort), .BASE_ADDR(base),
    .PKT_COUNT(pkt), .MODE_IN(mode_in), .MEM_ADDR(mem_addr), .MEM_RD(mem_rd),
    .MEM_DATA(mem_data), .TX_START(tx_start), .TX_DATA(tx_data), .TX_MODE(tx_mode),
    .TX_DONE(tx_done), .CTS(cts), .RTS(rts), .BUSY(busy), .DONE(done),
    .ERR_TIMEOUT(err), .SENT_COUNT(sent));

  uart_tx_sequencer #(.ADDR_W(8), .CNT_W(16), .CTS_TIMEOUT(TO_SHORT)) dut_t (
    .Clock(clk), .Reset(rst), .GO(go_t), .ABORT(abort), .BASE_ADDR(base),
    .PKT_COUNT(pkt), .MODE_IN(mode_in), .MEM_ADDR(t_mem_addr), .MEM_RD(t_mem_rd),
    .MEM_DATA(t_mem_data), .TX_START(t_tx_start), .TX_DATA(t_tx_data), .TX_MODE(t_tx_mode),
    .TX_DONE(t_tx_done), .CTS(cts), .RTS(t_rts), .BUSY(t_busy), .DONE(t_done),
    .ERR_TIMEOUT(t_err), .SENT_COUNT(t_sent));

  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  int n_cmp = 0, n_bad = 0, cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: where the burst is, in terms of bytes and waits.
  typedef enum {P_IDLE, P_READ, P_GATE, P_PULSE, P_FLY, P_END} phase_t;
  phase_t     ph = P_IDLE;
  int         rd_age = 0, waited = 0, m_sent = 0, m_rem = 0;
  logic [7:0] m_addr = '0, m_data = '0, m_mode = '0;
  logic       m_err = 1'b0;
  int         go_cyc = 0, done_cyc = 0, rise_cyc = 0, n_done = 0, n_rts = 0, fly_cnt = 0;
  logic       cts_prev = 1'b1;
  int         start_q[$];
  logic [7:0] data_q[$], addr_q[$];

  task automatic model_step();
    if (rst) begin
      ph = P_IDLE; m_addr = '0; m_data = '0; m_mode = '0; m_err = 1'b0; m_sent = 0; m_rem = 0;
      return;
    end
    case (ph)
      P_IDLE: if (go) begin
        go_cyc = cyc - 1;
        m_err = 1'b0; m_sent = 0;
        if (pkt == 0) ph = P_END;
        else begin m_addr = base; m_rem = pkt; m_mode = mode_in; ph = P_READ; rd_age = 0; end
      end
      P_READ: begin
        if (rd_age == 1) m_data = mem[m_addr];
        if (abort) ph = P_END;
        else if (rd_age == 1) begin ph = P_GATE; waited = 0; end
        else rd_age = 1;
      end
      P_GATE: begin
        if (abort) ph = P_END;
        else if (cts) ph = P_PULSE;
        else if (waited == TO_MAIN - 1) begin m_err = 1'b1; ph = P_END; end
        else waited++;
      end
      P_PULSE: ph = P_FLY;
      P_FLY: if (tx_done) begin
        m_sent++; m_rem--; m_addr = m_addr + 8'd1;
        ph = (m_rem == 0 || abort) ? P_END : P_READ;
        rd_age = 0;
      end
      default: ph = P_IDLE;
    endcase
  endtask

  always @(posedge clk) begin
    #2;
    cyc++;
    model_step();
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_rd", mem_rd, (ph == P_READ && rd_age == 0));
    chk("tx_start", tx_start, (ph == P_PULSE));
    chk("tx_data", tx_data, m_data);
    chk("tx_mode", tx_mode, m_mode);
    chk("rts", rts, (ph == P_READ || ph == P_GATE || ph == P_PULSE || ph == P_FLY));
    chk("busy", busy, (ph != P_IDLE));
    chk("done", done, (ph == P_END));
    chk("err_timeout", err, m_err);
    chk("sent_count", sent, m_sent);
    if (tx_start) begin start_q.push_back(cyc); data_q.push_back(tx_data); fly_cnt = SER_DLY + 1; end
    if (mem_rd) addr_q.push_back(mem_addr);
    if (done) begin n_done++; done_cyc = cyc; end
    if (rts) n_rts++;
    // CTS is driven mid-cycle, so a first high sample means it rose in the previous cycle.
    if (cts && !cts_prev) rise_cyc = cyc - 1;
    cts_prev = cts;
  end

  always @(negedge clk) begin
    tx_done = 1'b0;
    if (fly_cnt > 0) begin
      fly_cnt--;
      if (fly_cnt == 0) tx_done = 1'b1;
    end
  end

  task automatic start_burst(input logic [7:0] b, input logic [15:0] n, input logic [7:0] m);
    base = b; pkt = n; mode_in = m; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 3000) begin @(negedge clk); k++; end
    chk({tag, "_idle_reached"}, busy, 1'b0);
    @(negedge clk);
  endtask

  task automatic wait_starts(input int n);
    int k = 0;
    while (start_q.size() < n && k < 500) begin @(negedge clk); k++; end
    chk("start_wait", (start_q.size() >= n), 1'b1);
  endtask

  task automatic clear_logs();
    start_q.delete(); data_q.delete(); addr_q.delete();
    n_done = 0; n_rts = 0;
  endtask

  initial begin
    int k_done, n_t_start;
    logic err_pre, err_at, rts_at;
    logic [15:0] sent_at;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    mem[8'h10] = 8'hA5; mem[8'h11] = 8'h3C; mem[8'h12] = 8'hFF;
    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33;

    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_rts", rts, 1'b0);
    chk("reset_sent", sent, 16'd0);
    chk("reset_mem_addr", mem_addr, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // Basic three-byte burst.
    clear_logs();
    start_burst(8'h10, 16'd3, 8'hA3);
    wait_idle("basic");
    chk("basic_n_start", start_q.size(), 3);
    if (data_q.size() == 3) begin
      chk("basic_byte0", data_q[0], 8'hA5);
      chk("basic_byte1", data_q[1], 8'h3C);
      chk("basic_byte2", data_q[2], 8'hFF);
      chk("basic_go_latency", start_q[0] - go_cyc, 4);
      chk("basic_start_gap", start_q[1] - start_q[0], SER_DLY + 4);
    end
    chk("basic_sent", sent, 16'd3);
    chk("basic_n_done", n_done, 1);
    chk("basic_rts_after", rts, 1'b0);
    chk("basic_mode", tx_mode, 8'hA3);

    // Zero-length request.
    clear_logs();
    start_burst(8'h40, 16'd0, 8'h00);
    wait_idle("zero");
    chk("zero_n_done", n_done, 1);
    chk("zero_done_latency", done_cyc - go_cyc, 1);
    chk("zero_n_rd", addr_q.size(), 0);
    chk("zero_n_start", start_q.size(), 0);
    chk("zero_rts_cycles", n_rts, 0);
    chk("zero_sent", sent, 16'd0);

    // CTS held low for 100 cycles, well inside the timeout.
    clear_logs();
    cts = 1'b0;
    start_burst(8'h20, 16'd1, 8'h00);
    repeat (100) @(negedge clk);
    cts = 1'b1;
    wait_idle("flow");
    chk("flow_n_start", start_q.size(), 1);
    if (start_q.size() > 0) chk("flow_start_after_cts", start_q[0], rise_cyc + 1);
    chk("flow_err", err, 1'b0);

    // Address wrap.
    clear_logs();
    start_burst(8'hFE, 16'd3, 8'h00);
    wait_idle("wrap");
    chk("wrap_n_rd", addr_q.size(), 3);
    if (addr_q.size() == 3) begin
      chk("wrap_addr0", addr_q[0], 8'hFE);
      chk("wrap_addr1", addr_q[1], 8'hFF);
      chk("wrap_addr2", addr_q[2], 8'h00);
    end
    if (data_q.size() == 3) chk("wrap_byte2", data_q[2], 8'h33);
    chk("wrap_final_addr", mem_addr, 8'h01);

    // Abort while byte 2 of 5 is in flight.
    clear_logs();
    start_burst(8'h30, 16'd5, 8'h00);
    wait_starts(2);
    abort = 1'b1;
    wait_idle("abort_tx");
    abort = 1'b0;
    chk("abort_tx_n_start", start_q.size(), 2);
    chk("abort_tx_sent", sent, 16'd2);
    chk("abort_tx_n_done", n_done, 1);

    // Abort while waiting for CTS.
    clear_logs();
    cts = 1'b0;
    start_burst(8'h50, 16'd2, 8'h00);
    repeat (6) @(negedge clk);
    abort = 1'b1;
    wait_idle("abort_cts");
    abort = 1'b0;
    cts = 1'b1;
    chk("abort_cts_n_start", start_q.size(), 0);
    chk("abort_cts_n_rd", addr_q.size(), 1);
    chk("abort_cts_sent", sent, 16'd0);
    chk("abort_cts_err", err, 1'b0);
    chk("abort_cts_n_done", n_done, 1);

    // MODE_IN changes mid-burst.
    clear_logs();
    start_burst(8'h10, 16'd2, 8'h5A);
    repeat (3) @(negedge clk);
    mode_in = 8'hC3;
    wait_idle("mode");
    chk("mode_held", tx_mode, 8'h5A);
    chk("mode_sent", sent, 16'd2);

    // CTS timeout on the short-timeout instance.
    cts = 1'b0; base = 8'h00; pkt = 16'd1; go_t = 1'b1;
    @(negedge clk);
    go_t = 1'b0;
    k_done = 0; n_t_start = 0; err_pre = 1'b1; err_at = 1'b0; rts_at = 1'b1; sent_at = '1;
    for (int k = 1; k <= 40; k++) begin
      if (t_tx_start) n_t_start++;
      if (k == 18) err_pre = t_err;
      if (t_done && k_done == 0) begin k_done = k; err_at = t_err; sent_at = t_sent; rts_at = t_rts; end
      @(negedge clk);
    end
    chk("timeout_done_cycle", k_done, 19);
    chk("timeout_err_before", err_pre, 1'b0);
    chk("timeout_err_at_done", err_at, 1'b1);
    chk("timeout_sent", sent_at, 16'd0);
    chk("timeout_rts_at_done", rts_at, 1'b0);
    chk("timeout_n_start", n_t_start, 0);
    chk("timeout_err_sticky", t_err, 1'b1);
    chk("timeout_busy_after", t_busy, 1'b0);
    pkt = 16'd0; go_t = 1'b1;
    @(negedge clk);
    go_t = 1'b0;
    chk("timeout_clear_done", t_done, 1'b1);
    chk("timeout_clear_err", t_err, 1'b0);
    cts = 1'b1;
    @(negedge clk);

    // Reset in the middle of a byte.
    clear_logs();
    start_burst(8'h10, 16'd3, 8'h81);
    wait_starts(1);
    repeat (3) @(negedge clk);
    chk("rst_mid_busy_before", busy, 1'b1);
    rst = 1'b1; fly_cnt = 0;
    @(negedge clk);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_rts", rts, 1'b0);
    chk("rst_mid_tx_data", tx_data, 8'h00);
    chk("rst_mid_tx_mode", tx_mode, 8'h00);
    chk("rst_mid_mem_addr", mem_addr, 8'h00);
    chk("rst_mid_sent", sent, 16'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    n_bad++;
    $display("FAIL watchdog at cycle %0d: got no end of run, want end within 40000 cycles", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_sequencer.md
Name: uart_tx_sequencer

Overview:
Controller that sequences the serial transmitter through a burst of bytes held in a byte-wide memory. It runs the CTS/RTS flow-control handshake and latches the 8-bit operating mode so the mode stays stable for the whole burst. It issues one start per byte and counts packets down. It sits between the system control/memory and the Tx serializer, and replaces the serializer's internal packet counter and fixed data register.

Parameters:
ADDR_W, 8, memory address width
CNT_W, 16, packet counter width
CTS_TIMEOUT, 50000, Clock cycles allowed in WAIT_CTS before abort with error

Ports:
Clock  in  1  system clock; all logic on rising edge
Reset  in  1  synchronous, active-high reset
GO  in  1  single-cycle request to start a burst; honoured only in IDLE
ABORT  in  1  level; request to stop the burst early
BASE_ADDR  in  ADDR_W  first byte address, sampled on accepted GO
PKT_COUNT  in  CNT_W  number of bytes to send, sampled on accepted GO
MODE_IN  in  8  operating mode: [7:6] baud select, [5] stop bits (0=two, 1=one), [1] parity sense, [0] parity enable
MEM_ADDR  out  ADDR_W  memory read address
MEM_RD  out  1  read strobe; MEM_DATA is valid exactly 1 cycle later
MEM_DATA  in  8  memory read data
TX_START  out  1  one-cycle start pulse to the serializer
TX_DATA  out  8  byte to transmit; held stable from TX_START until TX_DONE
TX_MODE  out  8  mode latched at GO; constant during a burst
TX_DONE  in  1  one-cycle pulse from the serializer after the last stop bit
CTS  in  1  receiver clear-to-send (high = ready)
RTS  out  1  request-to-send
BUSY  out  1  high in every state except IDLE
DONE  out  1  one-cycle pulse at end of burst (normal, aborted or timed out)
ERR_TIMEOUT  out  1  sticky; set on CTS timeout
SENT_COUNT  out  CNT_W  bytes completed in the current or last burst

Behaviour:
- Reset values: state=IDLE; MEM_ADDR=0, MEM_RD=0, TX_START=0, TX_DATA=0, TX_MODE=0, RTS=0, BUSY=0, DONE=0, ERR_TIMEOUT=0, SENT_COUNT=0; internal remaining count=0, timeout counter=0. Reset overrides everything, including mid-burst; TX_START is never emitted in the reset cycle.
- IDLE, GO=1, PKT_COUNT=0: no transfer; DONE pulses on the next cycle; SENT_COUNT=0; ERR_TIMEOUT cleared.
- IDLE, GO=1, PKT_COUNT!=0: latch BASE_ADDR, PKT_COUNT and MODE_IN (into TX_MODE); clear ERR_TIMEOUT and SENT_COUNT; go to FETCH.
- FETCH, 1 cycle: MEM_RD=1 at MEM_ADDR; RTS=1 from here until FINISH. Go to WAIT_MEM.
- WAIT_MEM, 1 cycle: capture MEM_DATA into TX_DATA. Go to WAIT_CTS.
- WAIT_CTS: if CTS=1, go to SEND. Otherwise increment the timeout counter; when it reaches CTS_TIMEOUT-1, set ERR_TIMEOUT and go to FINISH. The timeout counter clears on entering WAIT_CTS.
- SEND, 1 cycle: TX_START=1. Go to WAIT_TX.
- WAIT_TX: wait for TX_DONE. On TX_DONE: SENT_COUNT+1, remaining-1, MEM_ADDR+1 (wraps modulo 2^ADDR_W). If remaining becomes 0 or ABORT=1, go to FINISH; otherwise go to FETCH. CTS is ignored while a byte is in flight.
- ABORT in FETCH, WAIT_MEM or WAIT_CTS: go directly to FINISH with no TX_START. ABORT in SEND or WAIT_TX: the current byte completes first.
- FINISH, 1 cycle: DONE=1, RTS=0. Go to IDLE.
- GO outside IDLE is ignored. TX_DONE outside WAIT_TX is ignored.
- Latency: GO to first TX_START is 4 cycles when CTS is already high. TX_DONE to the next TX_START is 4 cycles.

Decomposition:
- Package uart_pkg: state enum (IDLE, FETCH, WAIT_MEM, WAIT_CTS, SEND, WAIT_TX, FINISH); MODE_IN bit-field index constants; baud divisor constants 10416/5208/2604/868, shared with the serializer.
- One natural sub-module, cts_timeout_counter: a loadable down-counter with an expiry flag.

Test Plan:
- Basic burst: BASE_ADDR=0x10, PKT_COUNT=3, mem[0x10..0x12]=A5,3C,FF, CTS=1, TX_DONE 20 cycles after each start -> TX_DATA sequence A5,3C,FF; exactly 3 TX_START; SENT_COUNT=3; one DONE pulse; RTS low after FINISH.
- Zero count: GO with PKT_COUNT=0 -> DONE on the next cycle; no MEM_RD, no TX_START, RTS stays 0.
- Flow control and timeout: CTS=0 for 100 cycles then 1, CTS_TIMEOUT=1000 -> TX_START in the cycle after CTS rises. Separately, hold CTS=0 with CTS_TIMEOUT=16 -> ERR_TIMEOUT=1 after 16 cycles in WAIT_CTS, DONE pulses, SENT_COUNT=0.
- Address wrap: BASE_ADDR=0xFE, PKT_COUNT=3 -> MEM_ADDR reads 0xFE, 0xFF, 0x00.
- Abort: ABORT asserted during WAIT_TX of byte 2 of 5 -> byte 2 completes, SENT_COUNT=2, no further TX_START, DONE pulses. Separately, ABORT during WAIT_CTS -> no TX_START for that byte.
- Reset mid-burst, and mode latch: Reset asserted in WAIT_TX -> all outputs at reset values on the next cycle. MODE_IN changed mid-burst -> TX_MODE holds the value latched at GO.
